morse_arbiter: RTL and testbench

Round-robin controller that shares one Morse transmit datapath (letter LUT, 11-bit shift register, symbol-rate divider) between two requesters. It grants the transmitter to one requester at a time and issues the load pulse and letter code. It counts the datapath's symbol ticks to detect end of letter, then enforces an inter-letter silence before re-arbitrating. It sits between the requester logic and the transmit datapath, and drives that datapath's `Start` and `Letter` inputs.

---
 rtl/morse_pkg.sv | 17 +
 rtl/morse_arbiter_rr.sv | 34 +++
 rtl/morse_arbiter.sv | 123 ++++++++++++
 tb/tb_morse_arbiter.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse transmit arbiter.
// State encoding, frame length and the letter-code type used by the LUT.
package morse_pkg;

  localparam int TOTAL_BITS = 11;
  localparam int FREQDIV2_DEF = 250;

  typedef logic [2:0] letter_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    GAP
  } state_t;

endpackage

// File: rtl/morse_arbiter_rr.sv
// Two-input round-robin picker.
// A lone requester wins; on contention the one that is not last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win,
  output logic       next_last
);

  // pick the winner and the pointer value that follows it
  always_comb begin
    win       = 2'b00;
    next_last = last;
    unique case (1'b1)
      (req == 2'b11): begin
        win       = last ? 2'b01 : 2'b10;
        next_last = ~last;
      end
      (req == 2'b01): begin
        win       = 2'b01;
        next_last = 1'b0;
      end
      (req == 2'b10): begin
        win       = 2'b10;
        next_last = 1'b1;
      end
      default: begin
        win       = 2'b00;
        next_last = last;
      end
    endcase
  end

endmodule

// File: rtl/morse_arbiter.sv
// Round-robin owner of a shared Morse transmit datapath.
// Grants, loads a letter, counts symbol ticks, then holds a silent gap.
module morse_arbiter #(
  parameter int FREQdiv2   = morse_pkg::FREQDIV2_DEF,
  parameter int TOTAL_BITS = morse_pkg::TOTAL_BITS,
  parameter int GAP_BITS   = 3
) (
  input  logic       ClockIn,
  input  logic       Resetn,
  input  logic [1:0] Req,
  input  logic [2:0] Letter0,
  input  logic [2:0] Letter1,
  input  logic       NewBit,
  output logic       Start,
  output logic [2:0] LetterOut,
  output logic [1:0] Grant,
  output logic [1:0] Done,
  output logic       Busy
);

  import morse_pkg::*;

  localparam int GAP_CYC = GAP_BITS * FREQdiv2;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [3:0] BIT_LAST = 4'(TOTAL_BITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  state_t        state;
  state_t        state_n;
  logic [3:0]    bit_cnt;
  logic [3:0]    bit_cnt_n;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_cnt_n;
  logic          last;
  logic          last_n;
  logic          start_n;
  logic          busy_n;
  logic [1:0]    grant_n;
  logic [1:0]    done_n;
  letter_t       letter_n;
  logic [1:0]    win;
  logic          next_last;

  rr_arbiter2 u_rr (
    .req       (Req),
    .last      (last),
    .win       (win),
    .next_last (next_last)
  );

  // next-state, counters and registered-output values
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    last_n    = last;
    grant_n   = Grant;
    letter_n  = LetterOut;
    start_n   = 1'b0;
    done_n    = 2'b00;
    unique case (state)
      IDLE: begin
        if (win != 2'b00) begin
          letter_n = win[1] ? Letter1 : Letter0;
          grant_n  = win;
          last_n   = next_last;
          start_n  = 1'b1;
          state_n  = LOAD;
        end
      end
      LOAD: begin
        bit_cnt_n = 4'd0;
        state_n   = SEND;
      end
      SEND: begin
        if (NewBit) begin
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == BIT_LAST) begin
            done_n    = Grant;
            gap_cnt_n = '0;
            state_n   = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          grant_n = 2'b00;
          state_n = IDLE;
        end else begin
          gap_cnt_n = gap_cnt + GW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // state and output registers
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      gap_cnt   <= '0;
      last      <= 1'b1;
      Grant     <= 2'b00;
      LetterOut <= 3'b000;
      Start     <= 1'b0;
      Done      <= 2'b00;
      Busy      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      gap_cnt   <= gap_cnt_n;
      last      <= last_n;
      Grant     <= grant_n;
      LetterOut <= letter_n;
      Start     <= start_n;
      Done      <= done_n;
      Busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_morse_arbiter.sv
// Bench for morse_arbiter with a small symbol-tick model.
// Grants and letters are queued at request time and checked on Start/Done.
module tb_morse_arbiter;

  typedef struct packed {
    logic [1:0] g;
    logic [2:0] l;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [2:0] l0;
  logic [2:0] l1;
  logic       m_tick = 1'b0;
  logic       s_tick = 1'b0;
  logic       tick;
  logic       start;
  logic [2:0] lout;
  logic [1:0] grant;
  logic [1:0] done;
  logic       busy;

  int total = 0;
  int bad = 0;
  int start_seen = 0;
  int done_seen = 0;
  int tick_cnt = 0;

  exp_t       exp_q[$];
  logic [1:0] done_q[$];
  exp_t       e;
  logic [1:0] dq;

  assign tick = m_tick | s_tick;

  morse_arbiter #(
    .FREQdiv2   (4),
    .TOTAL_BITS (11),
    .GAP_BITS   (3)
  ) dut (
    .ClockIn   (clk),
    .Resetn    (rst_n),
    .Req       (req),
    .Letter0   (l0),
    .Letter1   (l1),
    .NewBit    (tick),
    .Start     (start),
    .LetterOut (lout),
    .Grant     (grant),
    .Done      (done),
    .Busy      (busy)
  );

  always #5 clk = ~clk;

  // datapath model: 11 ticks, one every 4 cycles, after each Start
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && start === 1'b1) begin
        tick_cnt = 0;
        for (int i = 0; i < 11; i++) begin
          repeat (3) @(posedge clk);
          if (rst_n !== 1'b1) break;
          #1 m_tick = 1'b1;
          tick_cnt++;
          @(posedge clk);
          #1 m_tick = 1'b0;
        end
      end
    end
  end

  // scoreboard: pop expected grant/letter on Start, owner on Done
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (start === 1'b1) begin
        start_seen++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL start_unexpected grant=%b letter=%b", grant, lout);
        end else begin
          e = exp_q.pop_front();
          if (grant !== e.g) begin
            bad++;
            $display("FAIL start_grant got=%b exp=%b", grant, e.g);
          end
          total++;
          if (lout !== e.l) begin
            bad++;
            $display("FAIL start_letter got=%b exp=%b", lout, e.l);
          end
          done_q.push_back(e.g);
        end
      end
      if (done !== 2'b00) begin
        done_seen++;
        total++;
        if (done_q.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected got=%b exp=none", done);
        end else begin
          dq = done_q.pop_front();
          if (done !== dq) begin
            bad++;
            $display("FAIL done_owner got=%b exp=%b", done, dq);
          end
        end
        total++;
        if (tick_cnt != 11) begin
          bad++;
          $display("FAIL done_ticks got=%0d exp=11", tick_cnt);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_start(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (start_seen > base) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_done(input int base, input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done_seen >= base + n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (grant === 2'b00 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 2'b00;
    l0 = 3'b000;
    l1 = 3'b000;
    repeat (3) step();
    total++;
    if ({start, grant, done, lout, busy} !== 9'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0",
               {start, grant, done, lout, busy});
    end
    rst_n = 1'b1;
    repeat (2) step();
    total++;
    if (busy !== 1'b0 || grant !== 2'b00) begin
      bad++;
      $display("FAIL reset_idle busy=%b grant=%b exp=0,00", busy, grant);
    end
  endtask

  task automatic test_single();
    bit ok;
    int b;
    int n;
    step();
    b = done_seen;
    l0 = 3'b010;
    req = 2'b01;
    exp_q.push_back(exp_t'{g: 2'b01, l: 3'b010});
    step();
    total++;
    if (start !== 1'b1 || grant !== 2'b01 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_start start=%b grant=%b busy=%b exp=1,01,1",
               start, grant, busy);
    end
    total++;
    if (lout !== 3'b010) begin
      bad++;
      $display("FAIL single_letter got=%b exp=010", lout);
    end
    step();
    total++;
    if (start !== 1'b0) begin
      bad++;
      $display("FAIL single_start_fall got=%b exp=0", start);
    end
    wait_done(b, 1, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL single_done_timeout got=none exp=done");
    end
    req = 2'b00;
    n = 0;
    while (grant !== 2'b00 && n < 40) begin
      step();
      n++;
    end
    total++;
    if (n != 12 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_gap got=%0d busy=%b exp=12 busy=0", n, busy);
    end
  endtask

  task automatic test_drop();
    bit ok;
    int b;
    int s;
    int n;
    step();
    b = done_seen;
    s = start_seen;
    l1 = 3'b011;
    req = 2'b10;
    exp_q.push_back(exp_t'{g: 2'b10, l: 3'b011});
    wait_start(s, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drop_start_timeout got=none exp=start");
    end
    repeat (8) step();
    req = 2'b00;
    step();
    total++;
    if (grant !== 2'b10) begin
      bad++;
      $display("FAIL drop_grant_held got=%b exp=10", grant);
    end
    wait_done(b, 1, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drop_done_timeout got=none exp=done");
    end
    n = 0;
    while (grant !== 2'b00 && n < 40) begin
      step();
      n++;
    end
    total++;
    if (n != 12) begin
      bad++;
      $display("FAIL drop_gap got=%0d exp=12", n);
    end
  endtask

  task automatic test_contention();
    bit ok;
    int b;
    int s;
    step();
    b = done_seen;
    s = start_seen;
    l0 = 3'b100;
    l1 = 3'b011;
    req = 2'b11;
    exp_q.push_back(exp_t'{g: 2'b01, l: 3'b100});
    exp_q.push_back(exp_t'{g: 2'b10, l: 3'b011});
    exp_q.push_back(exp_t'{g: 2'b01, l: 3'b100});
    wait_done(b, 3, ok);
    req = 2'b00;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL contention_timeout got=%0d exp=3", done_seen - b);
    end
    wait_idle(ok);
    step();
    total++;
    if (!ok || start_seen - s != 3) begin
      bad++;
      $display("FAIL contention_frames got=%0d exp=3", start_seen - s);
    end
  endtask

  task automatic test_letter_change();
    bit ok;
    int b;
    int s;
    step();
    b = done_seen;
    s = start_seen;
    l0 = 3'b001;
    req = 2'b01;
    exp_q.push_back(exp_t'{g: 2'b01, l: 3'b001});
    wait_start(s, ok);
    repeat (10) step();
    l0 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (lout !== 3'b001) begin
        bad++;
        $display("FAIL letter_hold got=%b exp=001", lout);
      end
    end
    wait_done(b, 1, ok);
    req = 2'b00;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL letter_done_timeout got=none exp=done");
    end
    wait_idle(ok);
    step();
    s = start_seen;
    b = done_seen;
    req = 2'b01;
    exp_q.push_back(exp_t'{g: 2'b01, l: 3'b111});
    wait_start(s, ok);
    total++;
    if (!ok || lout !== 3'b111) begin
      bad++;
      $display("FAIL letter_next got=%b exp=111", lout);
    end
    wait_done(b, 1, ok);
    req = 2'b00;
    wait_idle(ok);
  endtask

  task automatic test_stray();
    bit ok;
    int b;
    int n;
    step();
    for (int i = 0; i < 2; i++) begin
      s_tick = 1'b1;
      step();
      s_tick = 1'b0;
      step();
    end
    total++;
    if (busy !== 1'b0 || grant !== 2'b00) begin
      bad++;
      $display("FAIL stray_idle busy=%b grant=%b exp=0,00", busy, grant);
    end
    b = done_seen;
    l1 = 3'b101;
    req = 2'b10;
    exp_q.push_back(exp_t'{g: 2'b10, l: 3'b101});
    wait_done(b, 1, ok);
    req = 2'b00;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL stray_done_timeout got=none exp=done");
    end
    n = 0;
    while (grant !== 2'b00 && n < 40) begin
      s_tick = (n == 3);
      step();
      n++;
    end
    s_tick = 1'b0;
    total++;
    if (n != 12) begin
      bad++;
      $display("FAIL stray_gap got=%0d exp=12", n);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int b;
    int s;
    step();
    s = start_seen;
    l0 = 3'b110;
    req = 2'b01;
    exp_q.push_back(exp_t'{g: 2'b01, l: 3'b110});
    wait_start(s, ok);
    for (int i = 0; i < 60 && tick_cnt < 5; i++) step();
    total++;
    if (tick_cnt != 5 || grant !== 2'b01) begin
      bad++;
      $display("FAIL rmid_prep ticks=%0d grant=%b exp=5,01", tick_cnt, grant);
    end
    b = done_seen;
    #2;
    rst_n = 1'b0;
    req = 2'b00;
    #1;
    total++;
    if ({grant, busy, start, done} !== 6'b0) begin
      bad++;
      $display("FAIL rmid_async got=%b exp=000000",
               {grant, busy, start, done});
    end
    done_q.delete();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (60) step();
    total++;
    if (done_seen != b || busy !== 1'b0) begin
      bad++;
      $display("FAIL rmid_no_done got=%0d busy=%b exp=%0d,0",
               done_seen, busy, b);
    end
    s = start_seen;
    b = done_seen;
    l1 = 3'b010;
    req = 2'b11;
    exp_q.push_back(exp_t'{g: 2'b01, l: 3'b110});
    wait_start(s, ok);
    total++;
    if (!ok || grant !== 2'b01) begin
      bad++;
      $display("FAIL rmid_first got=%b exp=01", grant);
    end
    wait_done(b, 1, ok);
    req = 2'b00;
    wait_idle(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rmid_idle_timeout got=busy exp=idle");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_drop();
    test_contention();
    test_letter_change();
    test_stray();
    test_reset_mid();
    repeat (4) step();
    total++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      bad++;
      $display("FAIL queues_left got=%0d/%0d exp=0/0",
               exp_q.size(), done_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
